// File: rtl/arb_req_pkg.sv
// Shared types, default sizing and one-hot helpers for the arbiter requester bank.
package arb_req_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam int N_DEF         = 8;
    localparam int CNT_W_DEF     = 4;
    localparam int BURST_LEN_DEF = 4;

    // Helpers operate on a zero-extended 32-bit vector so any N up to 32 can use them.
    localparam int VEC_W = 32;

    function automatic logic is_onehot(input logic [VEC_W-1:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    function automatic logic [VEC_W-1:0] onehot_to_idx(input logic [VEC_W-1:0] v);
        logic [VEC_W-1:0] idx;
        idx = 32'd0;
        for (int i = 0; i < VEC_W; i++) begin
            if (v[i]) begin
                idx = idx | 32'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_pend_counter.sv
// One client's saturating pending-transaction counter with a sticky overflow flag.
module arb_pend_counter
    import arb_req_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic count_nz,
    output logic overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;
    logic             overflow_r;

    // Simultaneous push and completion cancel out; a push at saturation is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else if (inc && !dec) begin
            if (count_r == CNT_MAX) begin
                overflow_r <= 1'b1;
            end else begin
                count_r <= count_r + CNT_ONE;
            end
        end else if (dec && !inc) begin
            if (count_r != CNT_ZERO) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign count_nz = (count_r != CNT_ZERO);
    assign overflow = overflow_r;

endmodule

// File: rtl/arb_requester_bank.sv
// Requester bank: queues per-client transactions, drives a fixed-priority arbiter and
// holds the granted client for a BURST_LEN-beat transfer.
module arb_requester_bank
    import arb_req_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         push,
    output logic [N-1:0]         req,
    input  logic [N-1:0]         grant,
    output logic                 busy,
    output logic [$clog2(N)-1:0] active_id,
    output logic [3:0]           beat,
    output logic [N-1:0]         done,
    output logic [N-1:0]         overflow,
    output logic                 proto_err
);

    localparam int          ID_W      = $clog2(N);
    localparam logic [3:0]  LAST_BEAT = 4'(BURST_LEN - 1);
    localparam logic [N-1:0] VEC_ZERO = {N{1'b0}};
    localparam logic [N-1:0] VEC_ONE  = N'(1);

    state_t           state_r;
    logic [ID_W-1:0]  active_id_r;
    logic [3:0]       beat_r;
    logic [N-1:0]     done_r;
    logic             proto_err_r;

    logic [N-1:0]     pend_nz_s;
    logic [N-1:0]     dec_s;
    logic [N-1:0]     req_s;
    logic [N-1:0]     active_oh_s;
    logic             last_beat_s;
    logic             grant_legal_s;

    assign active_oh_s   = VEC_ONE << active_id_r;
    assign last_beat_s   = (beat_r == LAST_BEAT);
    assign grant_legal_s = is_onehot(VEC_W'(grant)) && ((grant & ~req_s) == VEC_ZERO);

    // Completion retires one queued transaction of the served client.
    always_comb begin
        dec_s = VEC_ZERO;
        if ((state_r == SERVE) && last_beat_s) begin
            dec_s = active_oh_s;
        end else begin
            dec_s = VEC_ZERO;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_pend
        arb_pend_counter #(
            .CNT_W (CNT_W)
        ) u_pend (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (push[i]),
            .dec      (dec_s[i]),
            .count_nz (pend_nz_s[i]),
            .overflow (overflow[i])
        );
    end

    // During a burst only the served client requests, so later arrivals cannot steal the grant.
    always_comb begin
        req_s = VEC_ZERO;
        if (state_r == SERVE) begin
            req_s = active_oh_s;
        end else begin
            req_s = pend_nz_s;
        end
    end

    // Burst FSM with beat counter, completion pulse and sticky protocol-error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            active_id_r <= {ID_W{1'b0}};
            beat_r      <= 4'd0;
            done_r      <= VEC_ZERO;
            proto_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= VEC_ZERO;
                    if (grant_legal_s) begin
                        state_r     <= SERVE;
                        active_id_r <= ID_W'(onehot_to_idx(VEC_W'(grant)));
                        beat_r      <= 4'd0;
                    end else if (grant != VEC_ZERO) begin
                        proto_err_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SERVE: begin
                    if (grant != active_oh_s) begin
                        proto_err_r <= 1'b1;
                    end else begin
                        proto_err_r <= proto_err_r;
                    end
                    if (last_beat_s) begin
                        state_r <= IDLE;
                        beat_r  <= 4'd0;
                        done_r  <= active_oh_s;
                    end else begin
                        beat_r  <= beat_r + 4'd1;
                        done_r  <= VEC_ZERO;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    beat_r  <= 4'd0;
                    done_r  <= VEC_ZERO;
                end
            endcase
        end
    end

    assign req       = req_s;
    assign busy      = (state_r == SERVE);
    assign active_id = active_id_r;
    assign beat      = beat_r;
    assign done      = done_r;
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_arb_requester_bank.sv
// Bench for arb_requester_bank: fixed-priority arbiter in the loop, directed scenarios
// plus random pushes, all compared against an integer-level reference model.
module tb_arb_requester_bank;

    localparam int N         = 8;
    localparam int CNT_W     = 4;
    localparam int BURST_LEN = 4;
    localparam int PEND_MAX  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] push;
    logic [7:0] req;
    logic [7:0] grant;
    logic       busy;
    logic [2:0] active_id;
    logic [3:0] beat;
    logic [7:0] done;
    logic [7:0] overflow;
    logic       proto_err;

    logic       force_en;
    logic [7:0] force_val;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Arbiter in the loop: lowest index wins; can be overridden to inject grants.
    assign grant = force_en ? force_val : (req & (~req + 8'd1));

    arb_requester_bank #(
        .N         (N),
        .CNT_W     (CNT_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .req       (req),
        .grant     (grant),
        .busy      (busy),
        .active_id (active_id),
        .beat      (beat),
        .done      (done),
        .overflow  (overflow),
        .proto_err (proto_err)
    );

    // Reference model state
    int         m_pend[N];
    bit         m_serving;
    int         m_active;
    int         m_beat;
    logic [7:0] m_done;
    logic [7:0] m_ovf;
    bit         m_perr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_req();
        logic [7:0] r;
        r = 8'd0;
        if (m_serving) r = 8'd1 << m_active;
        else for (int i = 0; i < N; i++) r[i] = (m_pend[i] > 0);
        return r;
    endfunction

    function automatic logic [7:0] model_grant(input logic [7:0] r);
        if (force_en) return force_val;
        for (int i = 0; i < N; i++) if (r[i]) return 8'd1 << i;
        return 8'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 0;
        m_serving = 1'b0;
        m_active  = 0;
        m_beat    = 0;
        m_done    = 8'd0;
        m_ovf     = 8'd0;
        m_perr    = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] push_v);
        logic [7:0] r;
        logic [7:0] g;
        int         dec_id;
        r      = model_req();
        g      = model_grant(r);
        dec_id = -1;
        m_done = 8'd0;
        if (!m_serving) begin
            if ($countones(g) == 1 && (g & ~r) == 8'd0) begin
                m_serving = 1'b1;
                m_beat    = 0;
                for (int i = 0; i < N; i++) if (g[i]) m_active = i;
            end else if (g != 8'd0) begin
                m_perr = 1'b1;
            end
        end else begin
            if (g != (8'd1 << m_active)) m_perr = 1'b1;
            if (m_beat == BURST_LEN - 1) begin
                m_serving = 1'b0;
                m_beat    = 0;
                dec_id    = m_active;
                m_done    = 8'd1 << m_active;
            end else begin
                m_beat++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (push_v[i] && i != dec_id) begin
                if (m_pend[i] == PEND_MAX) m_ovf[i] = 1'b1;
                else m_pend[i]++;
            end
        end
        if (dec_id >= 0 && !push_v[dec_id]) m_pend[dec_id]--;
    endtask

    task automatic check_outputs();
        check_eq("req",       req,       model_req());
        check_eq("busy",      busy,      m_serving);
        check_eq("active_id", active_id, m_active);
        check_eq("beat",      beat,      m_beat);
        check_eq("done",      done,      m_done);
        check_eq("overflow",  overflow,  m_ovf);
        check_eq("proto_err", proto_err, m_perr);
    endtask

    task automatic cycle(input logic [7:0] push_v);
        push = push_v;
        model_step(push_v);
        @(posedge clk);
        #1;
        push = 8'd0;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_beat(input int b, input string tag);
        int k;
        for (k = 0; k < 40; k++) begin
            if (m_serving && m_beat == b) break;
            cycle(8'd0);
        end
        check_eq(tag, (k < 40), 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        push      = 8'd0;
        force_en  = 1'b0;
        force_val = 8'd0;
        model_reset();
        #12;
        check_outputs();
        rst_n = 1'b1;

        // Single client burst
        cycle(8'h04);
        check_eq("s1_req", req, 8'h04);
        repeat (8) cycle(8'd0);

        // All clients at once, served in index order
        cycle(8'hFF);
        repeat (8 * (BURST_LEN + 1) + 4) cycle(8'd0);
        check_eq("s2_req_final", req, 8'h00);

        // Higher-priority arrival mid-burst must not steal the grant
        cycle(8'h20);
        wait_beat(1, "s3_reach_beat1");
        cycle(8'h01);
        check_eq("s3_req_locked", req, 8'h20);
        repeat (12) cycle(8'd0);

        // Saturation with the arbiter disconnected
        force_en  = 1'b1;
        force_val = 8'd0;
        repeat (16) cycle(8'h08);
        check_eq("s4_ovf3", overflow[3], 1'b1);
        check_eq("s4_req3", req[3], 1'b1);
        force_en = 1'b0;
        repeat (PEND_MAX * (BURST_LEN + 1) + 5) cycle(8'd0);

        // Multi-hot grant in IDLE
        force_en  = 1'b1;
        force_val = 8'd0;
        cycle(8'h03);
        force_val = 8'h03;
        cycle(8'd0);
        check_eq("s5_perr", proto_err, 1'b1);
        check_eq("s5_idle", busy, 1'b0);
        force_en = 1'b0;
        repeat (12) cycle(8'd0);

        // Reset in the middle of a burst
        do_reset();
        cycle(8'h02);
        wait_beat(2, "s6_reach_beat2");
        do_reset();
        repeat (8) cycle(8'd0);

        // Random traffic with occasional injected grants and one mid-run reset
        for (int it = 0; it < 400; it++) begin
            logic [7:0] pv;
            for (int i = 0; i < N; i++) pv[i] = ($urandom_range(7) == 0);
            if ($urandom_range(49) == 0) begin
                force_en  = 1'b1;
                force_val = 8'($urandom);
            end else begin
                force_en  = 1'b0;
            end
            if (it == 200) do_reset();
            cycle(pv);
        end
        force_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arb_requester_bank.md
Name: arb_requester_bank

Overview:
- Requester-side counterpart to the team's combinational 8-bit fixed-priority arbiter.
- Holds up to 2^CNT_W-1 pending transactions per client and drives the arbiter's req vector.
- Consumes the returned one-hot grant. Locks onto the granted client for a fixed BURST_LEN-beat transfer, then releases.
- Sits between client push strobes and the arbiter; emits per-client done pulses and protocol-error flags.

Parameters:
- N, 8, number of clients; width of req/grant.
- CNT_W, 4, width of each per-client pending counter; saturates at 2^CNT_W-1.
- BURST_LEN, 4, beats per granted transfer; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- push  in  N  per-client one-cycle strobe; queues one transaction for client i.
- req  out  N  request vector to the arbiter.
- grant  in  N  grant vector from the arbiter, combinational from req in the same cycle.
- busy  out  1  high while in SERVE.
- active_id  out  $clog2(N)  index of the client being served; holds its last value in IDLE.
- beat  out  4  current beat index within the burst, 0..BURST_LEN-1.
- done  out  N  registered one-cycle pulse on the client whose burst completed.
- overflow  out  N  sticky; set when a push arrives at a saturated counter.
- proto_err  out  1  sticky; set on an illegal grant.

Behaviour:
- Reset (rst_n=0, async):
  - pend[*]=0, state=IDLE, active_id=0, beat=0.
  - done=0, overflow=0, proto_err=0, busy=0.
  - req=0 as a consequence of the reset state.
- req is combinational from registered state only, never from grant:
  - IDLE: req[i] = (pend[i] != 0).
  - SERVE: req = onehot(active_id). This locks the arbiter so a higher-priority arrival cannot steal the grant mid-burst.
- FSM, two states:
  - IDLE -> SERVE when grant is nonzero, exactly one-hot, and a subset of req. Latch active_id = index of grant; beat = 0.
  - IDLE with an illegal grant (multi-hot, or a bit not in req): set proto_err, stay IDLE, ignore it.
  - SERVE: beat increments each cycle.
  - SERVE with beat == BURST_LEN-1: at the next edge go to IDLE, decrement pend[active_id], and set done[active_id]=1 for exactly one cycle.
  - SERVE with grant != onehot(active_id) in any cycle: set proto_err. The burst continues and is not aborted.
- Timing:
  - Push at edge t updates pend at t; req[i] is visible in cycle t..t+1.
  - Transition to SERVE occurs at the first edge where a legal grant is present.
  - busy is high for exactly BURST_LEN cycles per burst.
  - After done there is at least one IDLE cycle before the next SERVE; the returned req reflects the post-decrement counts.
- Counters:
  - push[i] and a decrement of pend[i] at the same edge: count unchanged.
  - push[i] at 2^CNT_W-1 with no decrement: count holds, overflow[i] sets.
  - Pushes to any client, including active_id, are accepted during SERVE.
- Edge cases:
  - Async reset mid-burst aborts immediately: no done, pending counts lost.
  - BURST_LEN=1: SERVE lasts one cycle.
  - done never asserts for more than one client at a time.

Decomposition:
- Package arb_req_pkg:
  - state enum {IDLE, SERVE}.
  - Default N/CNT_W/BURST_LEN constants.
  - onehot-to-index function.
  - is_onehot function.
- One sub-module: arb_pend_counter, a single client's saturating up/down counter with overflow flag. Instantiated N times via generate.
- The FSM, beat counter and req mux live in the top level.

Test Plan:
- Bench wiring for all scenarios: req drives the team's 8-bit fixed-priority arbiter (lowest index highest priority, lower group wins), whose grant feeds back.
- Reset, then push=8'b0000_0100 for 1 cycle -> req=0000_0100; next cycle busy=1, active_id=2, beat 0..3. done=0000_0100 for one cycle after beat 3; req returns to 0.
- push=8'b1111_1111 in one cycle -> bursts served in order 0,1,...,7. Each done is a single bit, 8 done pulses total, each separated by at least BURST_LEN+1 cycles. Final req=0.
- Serving client 5 (push 0010_0000); at beat 1 push 0000_0001 -> req stays 0010_0000 until client 5's done; client 0 is served next.
- push[3] 16 times with no grant (arbiter disconnected, grant forced 0) -> pend[3]=15 and overflow[3]=1 after the 16th push; req[3]=1.
- Forced grant=0000_0011 while req=0000_0011 -> proto_err=1, stays IDLE. Separately, assert rst_n=0 at beat 2 of a burst -> all outputs 0 asynchronously and no done afterwards.
